// File: rtl/witness_pkg.sv
// witness_pkg
//   Shared definitions for the witness generator slice. It provides the FSM
//   state enum, the bit positions of each witness variable inside w_out, and
//   the default fixed-point iteration bound.
//   Build option: WITNESS_CHECK_EN enables the CHECK state and the relation checker.
package witness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        FIX,
        CHECK,
        DONE
    } state_t;

    localparam int unsigned MAX_ITER_DEF = 4;
    localparam int unsigned W_WIDTH      = 9;

    // Bit positions of the witness variables inside w_out.
    localparam int unsigned W_I1  = 0;
    localparam int unsigned W_I2  = 1;
    localparam int unsigned W_I3  = 2;
    localparam int unsigned W_I7  = 3;
    localparam int unsigned W_I8  = 4;
    localparam int unsigned W_I9  = 5;
    localparam int unsigned W_I10 = 6;
    localparam int unsigned W_I11 = 7;
    localparam int unsigned W_I12 = 8;

endpackage

// File: rtl/witness_gen_if.sv
// witness_gen_if
//   This interface bundles the request and response handshakes of witness_gen.
//   master: drives in_valid, x_in, free_in and out_ready. It consumes the results.
//   slave : the witness_gen side. It drives in_ready, out_valid, w_out, iters,
//           check_ok and conv_err.
//   x_in    = {x_6,x_5,x_4,x_0}
//   free_in = {i_9,i_2}
//   Build option: WITNESS_CHECK_EN (see witness_gen).
interface witness_gen_if;
    import witness_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [3:0]         x_in;
    logic [1:0]         free_in;
    logic               out_valid;
    logic               out_ready;
    logic [W_WIDTH-1:0] w_out;
    logic [2:0]         iters;
    logic               check_ok;
    logic               conv_err;

    modport master (
        output in_valid, x_in, free_in, out_ready,
        input  in_ready, out_valid, w_out, iters, check_ok, conv_err
    );

    modport slave (
        input  in_valid, x_in, free_in, out_ready,
        output in_ready, out_valid, w_out, iters, check_ok, conv_err
    );

endinterface

// File: rtl/witness_check.sv
// witness_check
//   This is a combinational checker for the witness relation. It is built only
//   when WITNESS_CHECK_EN is defined.
//   x  : {x_6,x_5,x_4,x_0}
//   w  : witness vector, laid out by the witness_pkg W_* indices
//   ok : 1 when all seven relation equalities hold
`ifdef WITNESS_CHECK_EN
module witness_check
    import witness_pkg::*;
(
    input  logic [3:0]         x,
    input  logic [W_WIDTH-1:0] w,
    output logic               ok
);

    logic x0, x4, x5, x6;
    logic carry2;

    always_comb begin
        x0 = x[0];
        x4 = x[1];
        x5 = x[2];
        x6 = x[3];
        // Carry out of bit 1 of {x_4,x_0}+{x_6,x_5}.
        carry2 = (x4 & x6) | ((x0 & x5) & (x4 ^ x6));
        ok = (w[W_I7]  == (x0 ^ x5))
           & (w[W_I8]  == ((x0 & x5) ^ x4 ^ x6))
           & (w[W_I3]  == carry2)
           & (w[W_I1]  == ~w[W_I9])
           & (w[W_I10] == (x0 | w[W_I12]))
           & (w[W_I11] == (x4 & w[W_I10]))
           & (w[W_I12] == (x5 | w[W_I11]));
    end

endmodule
`endif

// File: rtl/witness_gen.sv
// witness_gen
//   This module builds a 9-bit witness from a 4-bit input and two free bits.
//   The sequence is:
//     ADD   : computes the adder bits.
//     FIX   : iterates the feedback equations to their least fixed point,
//             bounded by MAX_ITER.
//     CHECK : optionally checks the relation.
//     DONE  : presents the result until the consumer accepts it.
//   Ports: clk, rst_n (async, active-low), bus (witness_gen_if.slave).
//   Build option: WITNESS_CHECK_EN adds the CHECK state and the witness_check
//   instance. Without it, check_ok is 1 in DONE and 0 otherwise.
module witness_gen
    import witness_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    witness_gen_if.slave  bus
);

    state_t state, state_nxt;

    logic [3:0] x_r;
    logic [1:0] free_r;          // {i_9,i_2}
    logic       i1, i3, i7, i8;
    logic       i10, i11, i12;
    logic [2:0] cnt;
    logic       check_r;
    logic       conv_r;

    logic       x0, x4, x5, x6;
    logic [2:0] sum;
    logic       n10, n11, n12;
    logic       fix_conv;
    logic [2:0] cnt_nxt;
    logic       bound_hit;
    logic [W_WIDTH-1:0] w_cur;

    always_comb begin
        x0 = x_r[0];
        x4 = x_r[1];
        x5 = x_r[2];
        x6 = x_r[3];
        sum = {1'b0, x4, x0} + {1'b0, x6, x5};
        n10 = x0 | i12;
        n11 = x4 & i10;
        n12 = x5 | i11;
        fix_conv  = ({n10, n11, n12} == {i10, i11, i12});
        cnt_nxt   = cnt + 3'd1;
        bound_hit = (cnt_nxt == 3'(MAX_ITER));
    end

    always_comb begin
        w_cur        = '0;
        w_cur[W_I1]  = i1;
        w_cur[W_I2]  = free_r[0];
        w_cur[W_I3]  = i3;
        w_cur[W_I7]  = i7;
        w_cur[W_I8]  = i8;
        w_cur[W_I9]  = free_r[1];
        w_cur[W_I10] = i10;
        w_cur[W_I11] = i11;
        w_cur[W_I12] = i12;
    end

`ifdef WITNESS_CHECK_EN
    logic chk_ok;

    witness_check u_check (
        .x  (x_r),
        .w  (w_cur),
        .ok (chk_ok)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bus.in_valid) state_nxt = ADD;
            ADD:   state_nxt = FIX;
            FIX: begin
                // Convergence wins over the bound when both occur in the same cycle.
                if (fix_conv) begin
`ifdef WITNESS_CHECK_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end else if (bound_hit) begin
                    state_nxt = DONE;
                end
            end
            CHECK: state_nxt = DONE;
            DONE:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            free_r  <= '0;
            i1      <= 1'b0;
            i3      <= 1'b0;
            i7      <= 1'b0;
            i8      <= 1'b0;
            i10     <= 1'b0;
            i11     <= 1'b0;
            i12     <= 1'b0;
            cnt     <= '0;
            check_r <= 1'b0;
            conv_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r    <= bus.x_in;
                        free_r <= bus.free_in;
                    end
                end
                ADD: begin
                    i7      <= sum[0];
                    i8      <= sum[1];
                    i3      <= sum[2];
                    i1      <= ~free_r[1];
                    i10     <= 1'b0;
                    i11     <= 1'b0;
                    i12     <= 1'b0;
                    cnt     <= '0;
                    check_r <= 1'b0;
                    conv_r  <= 1'b0;
                end
                FIX: begin
                    cnt <= cnt_nxt;
                    // On a bound hit, the pre-update values are the ones reported.
                    if (!fix_conv && bound_hit) begin
                        conv_r <= 1'b1;
                    end else if (!fix_conv) begin
                        i10 <= n10;
                        i11 <= n11;
                        i12 <= n12;
                    end
                end
                CHECK: begin
`ifdef WITNESS_CHECK_EN
                    check_r <= chk_ok;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.w_out     = w_cur;
        bus.iters     = cnt;
        bus.conv_err  = conv_r;
`ifdef WITNESS_CHECK_EN
        bus.check_ok  = check_r;
`else
        bus.check_ok  = (state == DONE);
`endif
    end

endmodule

// File: tb/tb_witness_gen.sv
// tb_witness_gen
//   This is a randomized and directed bench for witness_gen. It uses a
//   behavioural reference model of the witness rules.
//   A second instance with MAX_ITER=3 exercises the non-convergence path.
module tb_witness_gen;

`ifdef WITNESS_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    witness_gen_if bus ();
    witness_gen_if bus3 ();

    witness_gen #(.MAX_ITER(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    witness_gen #(.MAX_ITER(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: evaluates the witness rules directly with integer arithmetic.
    function automatic void model(input logic [3:0] x, input logic [1:0] f, input int maxit,
                                  output logic [8:0] w, output int it, output logic ok,
                                  output logic err, output int lat);
        int s, a, b, c, na, nb, nc;
        int x0, x4, x5, x6;
        x0 = int'(x[0]); x4 = int'(x[1]); x5 = int'(x[2]); x6 = int'(x[3]);
        s = (x0 + 2 * x4) + (x5 + 2 * x6);
        a = 0; b = 0; c = 0; it = 0; err = 1'b0;
        forever begin
            na = x0 | c;
            nb = x4 & a;
            nc = x5 | b;
            it++;
            if (na == a && nb == b && nc == c) break;
            if (it == maxit) begin err = 1'b1; break; end
            a = na; b = nb; c = nc;
        end
        w = '0;
        w[0] = ~f[1];
        w[1] = f[0];
        w[2] = 1'((s / 4) % 2);
        w[3] = 1'(s % 2);
        w[4] = 1'((s / 2) % 2);
        w[5] = f[1];
        w[6] = 1'(a);
        w[7] = 1'(b);
        w[8] = 1'(c);
        if (CHK_EN == 0)
            ok = 1'b1;
        else if (err)
            ok = 1'b0;
        else
            ok = (w[3] == 1'(x0 ^ x5)) && (w[4] == 1'((x0 & x5) ^ x4 ^ x6))
              && (w[2] == 1'(s >= 4)) && (w[0] == ~w[5])
              && (a == (x0 | c)) && (b == (x4 & a)) && (c == (x5 | b));
        lat = 1 + it + ((CHK_EN != 0 && !err) ? 1 : 0) + 1;
    endfunction

    task automatic run_txn(input logic [3:0] x, input logic [1:0] f, input int hold,
                           input bit use_lit, input logic [8:0] w_lit, input string name);
        logic [8:0] ew;
        int         eit, elat, cyc;
        logic       eok, eerr;
        model(x, f, 4, ew, eit, eok, eerr, elat);
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready idle: got %b want 1", name, bus.in_ready);
        else n_pass++;
        bus.x_in = x; bus.free_in = f; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.x_in = 4'($urandom); bus.free_in = 2'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.out_valid !== 1'b1 && cyc < TIMEOUT);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL %s timeout: no out_valid after %0d cycles", name, cyc);
            return;
        end
        n_pass++;
        n_checks++;
        if (cyc !== elat) $display("FAIL %s latency: got %0d want %0d", name, cyc, elat);
        else n_pass++;
        n_checks++;
        if (bus.w_out !== ew) $display("FAIL %s w_out: got %h want %h", name, bus.w_out, ew);
        else n_pass++;
        if (use_lit) begin
            n_checks++;
            if (bus.w_out !== w_lit) $display("FAIL %s w_out literal: got %h want %h", name, bus.w_out, w_lit);
            else n_pass++;
        end
        n_checks++;
        if (int'(bus.iters) !== eit) $display("FAIL %s iters: got %0d want %0d", name, bus.iters, eit);
        else n_pass++;
        n_checks++;
        if (bus.check_ok !== eok) $display("FAIL %s check_ok: got %b want %b", name, bus.check_ok, eok);
        else n_pass++;
        n_checks++;
        if (bus.conv_err !== eerr) $display("FAIL %s conv_err: got %b want %b", name, bus.conv_err, eerr);
        else n_pass++;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'($urandom);
            bus.x_in = 4'($urandom);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.w_out !== ew || bus.in_ready !== 1'b0 || int'(bus.iters) !== eit)
                $display("FAIL %s stall %0d: got v=%b w=%h rdy=%b it=%0d want v=1 w=%h rdy=0 it=%0d",
                         name, k, bus.out_valid, bus.w_out, bus.in_ready, bus.iters, ew, eit);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", name, bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.x_in = '0; bus.free_in = '0;
        bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.x_in = '0; bus3.free_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.w_out, bus.iters, bus.check_ok, bus.conv_err} !== {1'b1, 1'b0, 9'h0, 3'h0, 1'b0, 1'b0})
            $display("FAIL reset: got rdy=%b v=%b w=%h it=%0d ok=%b err=%b want 1 0 000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.w_out, bus.iters, bus.check_ok, bus.conv_err);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_txn(4'b0000, 2'b00, 0, 1'b1, 9'h001, "zero");
        run_txn(4'b0011, 2'b00, 0, 1'b1, 9'h1D9, "x0x4");
        run_txn(4'b1111, 2'b11, 0, 1'b1, 9'h1F6, "ones");
    endtask

    task automatic test_stall();
        run_txn(4'b0101, 2'b10, 5, 1'b0, 9'h0, "stall");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++)
            run_txn(4'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'b0, 9'h0, "rand");
    endtask

    task automatic test_bound();
        logic [8:0] ew;
        int         eit, elat, cyc;
        logic       eok, eerr;
        model(4'b0011, 2'b00, 3, ew, eit, eok, eerr, elat);
        @(negedge clk);
        bus3.x_in = 4'b0011; bus3.free_in = 2'b00; bus3.in_valid = 1'b1; bus3.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus3.out_valid !== 1'b1 && cyc < TIMEOUT);
        n_checks++;
        if (bus3.out_valid !== 1'b1 || cyc !== elat)
            $display("FAIL bound latency: got v=%b cyc=%0d want v=1 cyc=%0d", bus3.out_valid, cyc, elat);
        else n_pass++;
        n_checks++;
        if (bus3.conv_err !== 1'b1 || bus3.iters !== 3'd3)
            $display("FAIL bound conv_err/iters: got %b/%0d want 1/3", bus3.conv_err, bus3.iters);
        else n_pass++;
        n_checks++;
        if (bus3.w_out !== ew || bus3.check_ok !== eok)
            $display("FAIL bound w_out/check_ok: got %h/%b want %h/%b", bus3.w_out, bus3.check_ok, ew, eok);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1)
            $display("FAIL bound release: got v=%b rdy=%b want 0 1", bus3.out_valid, bus3.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_fix();
        bit seen;
        @(negedge clk);
        bus.x_in = 4'b0011; bus.free_in = 2'b01; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.w_out, bus.iters, bus.check_ok, bus.conv_err} !== {1'b1, 1'b0, 9'h0, 3'h0, 1'b0, 1'b0})
            $display("FAIL midreset: got rdy=%b v=%b w=%h it=%0d ok=%b err=%b want 1 0 000 0 0 0",
                     bus.in_ready, bus.out_valid, bus.w_out, bus.iters, bus.check_ok, bus.conv_err);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midreset aborted: got out_valid=1 want 0");
        else n_pass++;
        run_txn(4'b0011, 2'b01, 0, 1'b0, 9'h0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_bound();
        test_random();
        test_reset_mid_fix();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/witness_gen.md
WITNESS_GEN -- requirements
Module: witness_gen

Interface
- REQ-001 SHALL have parameter MAX_ITER, default 4: fixed-point iteration bound, legal range 4..7.
- REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
- REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-004 SHALL have port in_valid, input, 1 bit: request valid.
- REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
- REQ-006 SHALL have port x_in, input, 4 bits: {x_6,x_5,x_4,x_0}.
- REQ-007 SHALL have port free_in, input, 2 bits: {i_9,i_2}, the unconstrained witness bits.
- REQ-008 SHALL have port out_valid, output, 1 bit: witness valid.
- REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the witness.
- REQ-010 SHALL have port w_out, output, 9 bits: [0]i_1 [1]i_2 [2]i_3 [3]i_7 [4]i_8 [5]i_9 [6]i_10 [7]i_11 [8]i_12.
- REQ-011 SHALL have port iters, output, 3 bits: number of fixed-point iterations used.
- REQ-012 SHALL have port check_ok, output, 1 bit: witness satisfies the relation.
- REQ-013 SHALL have port conv_err, output, 1 bit: fixed point not reached within MAX_ITER.

Function
- REQ-014 FSM SHALL have states IDLE, ADD, FIX, CHECK, DONE.
- REQ-015 in_ready SHALL be 1 only in IDLE; a handshake in IDLE SHALL register x_in and free_in and move to ADD.
- REQ-016 ADD (1 cycle): {i_8,i_7} SHALL equal bits[1:0] and i_3 SHALL equal bit 2 of the 3-bit sum {x_4,x_0}+{x_6,x_5}; i_1 = ~i_9; i_2 and i_9 from free_in; {i_10,i_11,i_12} cleared to 0; iteration counter cleared; next state FIX.
- REQ-017 FIX, each cycle: next i_10 = x_0|i_12, i_11 = x_4&i_10, i_12 = x_5|i_11, all from current register values; counter increments.
- REQ-018 FIX SHALL exit when next equals current (least fixed point); that cycle counts as an iteration; next state CHECK, or DONE when the check is compiled out.
- REQ-019 If the counter reaches MAX_ITER without convergence, FIX SHALL set conv_err=1 and go to DONE with the current values.
- REQ-020 CHECK (1 cycle) SHALL set check_ok = AND of all seven equalities: i_7==x_0^x_5, i_8==(x_0&x_5)^x_4^x_6, i_3==carry2, i_1==~i_9, i_10==x_0|i_12, i_11==x_4&i_10, i_12==x_5|i_11.
- REQ-021 DONE SHALL hold out_valid=1 with w_out, iters, check_ok and conv_err stable until out_ready=1; on handshake, go to IDLE; out_valid deasserts the following cycle.
- REQ-022 Latency from input handshake to out_valid SHALL be 1 (ADD) + iters + 1 (CHECK, if compiled in) + 1 cycles.
- REQ-023 in_valid outside IDLE SHALL be ignored; no request buffering.
- REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
- REQ-025 rst_n low SHALL asynchronously force IDLE, in_ready=1 (after reset release), out_valid=0, w_out=0, iters=0, check_ok=0, conv_err=0.
- REQ-026 Reset mid-operation SHALL abort the request without producing an output.

Configuration
- REQ-027 Macro WITNESS_CHECK_EN defined: CHECK state and checker logic are present.
- REQ-028 Macro WITNESS_CHECK_EN undefined: CHECK is skipped, check_ok is tied to 1 in DONE and to 0 otherwise, and latency drops by one cycle.

Structure
- REQ-029 A shared package witness_pkg SHALL hold the state enum, the w_out bit-index constants and the MAX_ITER default.
- REQ-030 The relation checker SHALL be sub-module witness_check: combinational, inputs x and w, output ok.

Verification
- REQ-031 x_in=0000, free_in=00, out_ready=1 -> w_out=0_0000_0001 (i_1=1), iters=1, check_ok=1, conv_err=0.
- REQ-032 x_0=1, x_4=1, others 0, free_in=00 -> i_7=1, i_8=1, i_3=0, i_10=i_11=i_12=1, iters=4, check_ok=1.
- REQ-033 x_in=1111, free_in=11 -> i_7=0, i_8=1, i_3=1, i_9=1, i_1=0, i_2=1, i_10..i_12=1, check_ok=1.
- REQ-034 MAX_ITER=4 with the REQ-032 stimulus -> conv_err=0; forcing the bound to 3 -> conv_err=1, iters=3.
- REQ-035 out_ready held 0 for 5 cycles -> out_valid and w_out stable, in_ready=0; out_ready=1 -> IDLE on the next cycle.
- REQ-036 rst_n pulsed low during FIX -> outputs take reset values immediately, no out_valid is produced, and the next request completes normally.
